// File: rtl/conv_pixel_streamer.sv
`default_nettype none
// ============================================================================
// Module   : conv_pixel_streamer
// Brief    : Streams one frame from a synchronous frame buffer into the Sobel
//            pixel interface, then appends zero pixels to drain its windows.
// Revision : 1.0 - initial release
// ============================================================================
module conv_pixel_streamer #(
    parameter int ROW_LENGTH = 1280,
    parameter int NUM_ROWS   = 960,
    parameter int ADDR_W     = 21,
    parameter int FLUSH_LEN  = 2*ROW_LENGTH+2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [11:0]       mem_rdata,
    output logic [11:0]       pix_out,
    output logic              pix_read,
    output logic              busy,
    output logic              done
);

    localparam int c_total   = NUM_ROWS * ROW_LENGTH;
    localparam int c_flush_w = ($clog2(FLUSH_LEN) > 0) ? $clog2(FLUSH_LEN) : 1;

    localparam logic [ADDR_W-1:0]    c_last_addr  = ADDR_W'(c_total - 1);
    localparam logic [ADDR_W-1:0]    c_addr_one   = ADDR_W'(1);
    localparam logic [c_flush_w-1:0] c_last_flush = c_flush_w'(FLUSH_LEN - 1);
    localparam logic [c_flush_w-1:0] c_flush_one  = c_flush_w'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    logic [ADDR_W-1:0]    r_addr;
    logic [c_flush_w-1:0] r_flush_cnt;
    logic                 r_rd_q;
    logic                 r_fl_q;
    logic                 r_busy;
    logic                 r_done;

    logic w_issue_rd;
    logic w_issue_fl;

    assign w_issue_rd = (r_state == S_FETCH) && !stall;
    assign w_issue_fl = (r_state == S_FLUSH) && !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_flush_cnt <= '0;
            r_rd_q      <= 1'b0;
            r_fl_q      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // Issue flags delayed one cycle line up with the memory read latency.
            r_rd_q <= w_issue_rd;
            r_fl_q <= w_issue_fl;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_FETCH;
                        r_addr  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (!stall) begin
                        // Address parks on the last word so it never leaves the frame.
                        if (r_addr == c_last_addr) begin
                            r_state     <= S_FLUSH;
                            r_flush_cnt <= '0;
                        end else begin
                            r_addr <= r_addr + c_addr_one;
                        end
                    end
                end
                S_FLUSH: begin
                    if (!stall) begin
                        if (r_flush_cnt == c_last_flush) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_flush_cnt <= r_flush_cnt + c_flush_one;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_rd   = w_issue_rd;
    assign mem_addr = r_addr;
    assign pix_read = r_rd_q | r_fl_q;
    assign pix_out  = r_rd_q ? mem_rdata : 12'd0;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_conv_pixel_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_pixel_streamer
// Brief    : Scoreboard bench for conv_pixel_streamer on a 4x3 frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_pixel_streamer;

    localparam int ROW_LENGTH = 4;
    localparam int NUM_ROWS   = 3;
    localparam int ADDR_W     = 8;
    localparam int FLUSH_LEN  = 10;
    localparam int TOTAL      = ROW_LENGTH * NUM_ROWS;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              stall;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [11:0]       mem_rdata;
    logic [11:0]       pix_out;
    logic              pix_read;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_pass   = 0;
    int sb_q[$];

    conv_pixel_streamer #(
        .ROW_LENGTH(ROW_LENGTH),
        .NUM_ROWS  (NUM_ROWS),
        .ADDR_W    (ADDR_W),
        .FLUSH_LEN (FLUSH_LEN)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stall    (stall),
        .mem_rd   (mem_rd),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .pix_out  (pix_out),
        .pix_read (pix_read),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Frame buffer: word[a] = a + 100, one cycle read latency.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= 12'(mem_addr) + 12'd100;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_rd"},   mem_rd,   0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_pix_read"}, pix_read, 0);
        check({tag, "_pix_out"},  pix_out,  0);
        check({tag, "_busy"},     busy,     0);
        check({tag, "_done"},     done,     0);
    endtask

    // Cycle 0 presents start; stall is high on cycles s_lo..s_hi.
    task automatic run_frame(input int s_lo, input int s_hi, input int exp_done,
                             input bit hold, input int abort_cyc);
        int reads;
        int exp_addr;
        int last;
        reads    = 0;
        exp_addr = 0;
        for (int i = 0; i < TOTAL; i++) sb_q.push_back(i + 100);
        for (int i = 0; i < FLUSH_LEN; i++) sb_q.push_back(0);

        @(negedge clk);
        start = 1'b1;
        stall = 1'b0;
        #1;
        check("start_cycle_busy", busy, 0);
        check("start_cycle_pix_read", pix_read, 0);

        last = hold ? exp_done : exp_done + 2;
        for (int cyc = 1; cyc <= last; cyc++) begin
            @(negedge clk);
            start = hold;
            stall = (cyc >= s_lo) && (cyc <= s_hi);
            if (cyc == abort_cyc) begin
                rst_n = 1'b0;
                #1;
                check_all_zero("abort");
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    #1;
                    check("abort_no_done", done, 0);
                end
                @(negedge clk);
                rst_n = 1'b1;
                start = 1'b0;
                stall = 1'b0;
                sb_q.delete();
                return;
            end
            #1;
            check("mem_rd", mem_rd, (reads < TOTAL) && !stall);
            if (mem_rd) begin
                check("mem_addr", mem_addr, exp_addr);
                exp_addr++;
                reads++;
            end
            if (s_lo <= s_hi && cyc == s_lo) check("pix_in_stall", pix_read, 1);
            if (pix_read) begin
                if (sb_q.size() == 0) check("extra_pixel", 1, 0);
                else check("pix_out", pix_out, sb_q.pop_front());
            end
            check("busy", busy, cyc <= exp_done);
            check("done", done, cyc == exp_done);
        end
        check("sb_empty", sb_q.size(), 0);
        if (!hold) start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        stall = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        #1;
        check("post_reset_busy", busy, 0);

        run_frame(0, -1, 23, 1'b0, -1);   // basic frame
        run_frame(5, 7, 26, 1'b0, -1);    // stall mid-fetch
        run_frame(15, 16, 25, 1'b0, -1);  // stall in flush
        run_frame(0, -1, 23, 1'b1, -1);   // start held through frame
        run_frame(0, -1, 23, 1'b0, -1);   // follow-on frame from held start
        run_frame(0, -1, 23, 1'b0, 9);    // reset mid-frame
        run_frame(0, -1, 23, 1'b0, -1);   // restart from address 0

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_pixel_streamer.md
Name: conv_pixel_streamer

Overview:
Frame source that feeds the Sobel convolution block's pixel-input interface (12-bit pixel plus per-pixel read strobe).
- On start, reads a grayscale frame from a synchronous frame-buffer memory in raster order, address 0 to NUM_ROWS*ROW_LENGTH-1.
- Emits one pixel per non-stalled cycle.
- Then emits FLUSH_LEN zero pixels so the convolution's two line buffers and 3x3 window drain.
- Sits between the frame-buffer read port and the convolution data_in/read inputs.

Parameters:
- ROW_LENGTH, 1280, pixels per row; must equal the convolution's ROW_LENGTH.
- NUM_ROWS, 960, rows per frame.
- ADDR_W, 21, memory address width; 2^ADDR_W >= NUM_ROWS*ROW_LENGTH.
- FLUSH_LEN, 2*ROW_LENGTH+2, number of trailing zero pixels.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin one frame; sampled only in IDLE
- stall  in  1  hold: no new fetch or flush issue while high
- mem_rd  out  1  memory read enable
- mem_addr  out  ADDR_W  memory read address
- mem_rdata  in  12  read data, valid exactly 1 cycle after mem_rd
- pix_out  out  12  pixel to convolution data_in
- pix_read  out  1  pixel strobe to convolution read
- busy  out  1  high in FETCH, FLUSH and DONE
- done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (async, any state): state=IDLE, address counter=0, flush counter=0, internal emit registers=0.
  - Outputs mem_rd=0, mem_addr=0, pix_out=0, pix_read=0, busy=0, done=0.
  - A reset mid-frame abandons the frame; no done pulse.
- TOTAL = NUM_ROWS*ROW_LENGTH.
- States:
  - IDLE: start=1 -> FETCH with addr=0. start=0 -> stay.
  - FETCH:
    - mem_rd = !stall (combinational); mem_addr = addr.
    - On an issued read, addr increments.
    - Read issued at addr==TOTAL-1 -> FLUSH with flush count=0.
  - FLUSH:
    - mem_rd=0.
    - Each cycle with !stall issues one zero pixel and increments the flush count.
    - Issue with count==FLUSH_LEN-1 -> DONE.
  - DONE: done=1 for this single cycle -> IDLE.
- Emission pipeline, uniform 1-cycle issue-to-emit latency:
  - rd_q <= (FETCH && !stall); fl_q <= (FLUSH && !stall).
  - pix_read = rd_q | fl_q. The two are never both high.
  - pix_out = rd_q ? mem_rdata : 12'd0.
- Stall:
  - Blocks only new issues. A read or flush issued in the previous cycle is still emitted while stall is high.
  - Counters and address hold while stalled.
  - Stall in IDLE or DONE has no effect.
- The last flush pixel is emitted in the same cycle that done=1.
- Pixels emitted per frame = TOTAL + FLUSH_LEN exactly, regardless of the stall pattern.
- start while busy (including during DONE) is ignored and not queued.
- mem_addr holds its last value outside FETCH. It returns to 0 only on reset or at the next start.
- Counters never exceed TOTAL-1 or FLUSH_LEN-1; no wrap-around within a frame.

Test Plan:
Bench parameters for all scenarios: ROW_LENGTH=4, NUM_ROWS=3, FLUSH_LEN=10; memory word[a] = a+100.
1. Reset: hold rst_n=0 with start=1 -> all outputs 0, busy=0; release -> IDLE.
2. Basic frame: start pulse at cycle 0, stall=0.
   - mem_rd high cycles 1-12, addresses 0..11.
   - pix_read high cycles 2-23.
   - pix_out = 100..111 on cycles 2-13, then 0 on cycles 14-23.
   - done=1 only at cycle 23; busy high cycles 1-23.
3. Stall mid-fetch: stall=1 on cycles 5-7 -> mem_rd low on 5-7; address 4 issued at cycle 8; pixel 103 still emitted at cycle 5; no pixel duplicated or dropped; done at cycle 26.
4. Stall in flush: stall=1 for 2 cycles during FLUSH -> exactly 10 zero pixels emitted; done delayed by 2 cycles.
5. start=1 held continuously through a frame -> second frame begins only from IDLE, one cycle after done; no overlap of pix_read between frames beyond the defined timing.
6. Async reset asserted at cycle 9 of a frame -> outputs 0 immediately; no done pulse; a new start re-reads from address 0.
